// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control path.
// Contents: opcode / funct3 constants, ALU operation codes, write-back and
// forwarding select encodings, the decoded control bundle (ctrl_t) with the
// slimmer bundles carried into MEM and WB, and a source-match helper used by
// the hazard logic.
package riscv_ctrl_pkg;

    localparam int REG_AW_P = 5;
    localparam int ALU_CW_P = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [ALU_CW_P-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_CW_P-1:0] ALU_SUB = 4'b1000;

    typedef enum logic [1:0] {
        WB_IMM = 2'b00,
        WB_ALU = 2'b01,
        WB_MEM = 2'b10,
        WB_PC4 = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // Full bundle as produced in ID and held in ID/EX. All-zero is a bubble.
    typedef struct packed {
        logic                alu_src_b;
        logic                alu_a_pc;
        logic [ALU_CW_P-1:0] alu_ctrl;
        logic                branch;
        logic                jal;
        logic                jalr;
        logic                mem_read;
        logic                mem_write;
        wb_sel_e             wb_sel;
        logic                rd_wen;
        logic [REG_AW_P-1:0] rd;
        logic [REG_AW_P-1:0] rs1;
        logic [REG_AW_P-1:0] rs2;
        logic                use_rs1;
        logic                use_rs2;
    } ctrl_t;

    // Only the fields still needed downstream travel into MEM and WB.
    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        wb_sel_e             wb_sel;
        logic                rd_wen;
        logic [REG_AW_P-1:0] rd;
    } mem_t;

    typedef struct packed {
        wb_sel_e             wb_sel;
        logic                rd_wen;
        logic [REG_AW_P-1:0] rd;
    } wb_t;

    // True when a stage that writes rd feeds a source register the ID
    // instruction actually reads. rd_wen is already clear for rd=x0.
    function automatic logic src_hit(ctrl_t id, logic wen, logic [REG_AW_P-1:0] rd);
        return wen && ((id.use_rs1 && (id.rs1 == rd)) || (id.use_rs2 && (id.rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: combinational RV32I main decoder.
// Ports:
//   instr   in  32  instruction word in ID
//   ctrl    out     decoded control bundle (all zero for an unknown opcode)
//   illegal out 1   opcode not recognised
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    // Remaining funct7 bits do not affect control.
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];
        case (opcode)
            OP_R: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = {f7b5, funct3};
                ctrl.wb_sel    = WB_ALU;
                ctrl.rd_wen    = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_IMM: begin
                // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate.
                ctrl.alu_ctrl = {(funct3 == F3_SR) ? f7b5 : 1'b0, funct3};
                ctrl.wb_sel   = WB_ALU;
                ctrl.rd_wen   = 1'b1;
                ctrl.use_rs1  = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.mem_read = 1'b1;
                ctrl.wb_sel   = WB_MEM;
                ctrl.rd_wen   = 1'b1;
                ctrl.use_rs1  = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.mem_write = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.use_rs1   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_JAL: begin
                ctrl.jal      = 1'b1;
                ctrl.alu_a_pc = 1'b1;
                ctrl.wb_sel   = WB_PC4;
                ctrl.rd_wen   = 1'b1;
            end
            OP_JALR: begin
                ctrl.jalr     = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.wb_sel   = WB_PC4;
                ctrl.rd_wen   = 1'b1;
                ctrl.use_rs1  = 1'b1;
            end
            OP_LUI: begin
                ctrl.wb_sel = WB_IMM;
                ctrl.rd_wen = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alu_a_pc = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.wb_sel   = WB_ALU;
                ctrl.rd_wen   = 1'b1;
            end
            default: begin
                ctrl    = '0;
                illegal = 1'b1;
            end
        endcase
        // x0 is hard-wired; never write it and never let it raise a hazard.
        if (ctrl.rd == '0) begin
            ctrl.rd_wen = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path of the 5-stage RV32I core.
// Decodes the ID instruction, carries the control bundle through ID/EX,
// EX/MEM and MEM/WB, and generates forwarding selects, load-use / RAW stalls
// and branch/jump flushes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_ID, instr_valid_ID instruction in ID and its valid flag
//   br_taken_EX              branch in EX resolved taken
//   stall_IF, flush_IF       hold / invalidate PC and IF/ID
//   illegal_ID               unknown opcode in ID (combinational)
//   *_EX                     control for the EX instruction (+ fwd selects)
//   mem_read_MEM, mem_write_MEM  data-memory strobes
//   wb_sel_WB, rd_wen_WB, rd_WB  register-file write-back control
//
// Handshake: instr_valid_ID acts as "valid" for the IF/ID slot and !stall_IF as
// "ready"; the ID instruction is consumed on a rising edge only when
// instr_valid_ID=1 and stall_IF=0, otherwise the fetch side must hold it.
// A flush consumes nothing: the ID slot is discarded.
module pipe_ctrl_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int FWD_EN  = 1,
    parameter int REG_AW  = 5,
    parameter int ALU_CW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_ID,
    input  logic              instr_valid_ID,
    input  logic              br_taken_EX,
    output logic              stall_IF,
    output logic              flush_IF,
    output logic              illegal_ID,
    output logic              alu_src_b_EX,
    output logic              alu_a_pc_EX,
    output logic [ALU_CW-1:0] alu_ctrl_EX,
    output logic              branch_EX,
    output logic              jal_EX,
    output logic              jalr_EX,
    output logic [1:0]        fwd_a_EX,
    output logic [1:0]        fwd_b_EX,
    output logic              mem_read_MEM,
    output logic              mem_write_MEM,
    output logic [1:0]        wb_sel_WB,
    output logic              rd_wen_WB,
    output logic [REG_AW-1:0] rd_WB
);

    ctrl_t      dec_c;
    ctrl_t      id_c;
    ctrl_t      ex_q;
    mem_t       mem_q;
    wb_t        wb_q;
    logic       dec_illegal;
    logic       flush;
    logic       load_use;
    logic       raw_stall;
    logic       stall;
    logic [1:0] stall_cnt;

    ctrl_decode u_decode (
        .instr   (instr_ID),
        .ctrl    (dec_c),
        .illegal (dec_illegal)
    );

    // An empty slot or an illegal opcode enters the pipe as a bubble.
    assign id_c       = (instr_valid_ID && !dec_illegal) ? dec_c : '0;
    assign illegal_ID = instr_valid_ID && dec_illegal;

    assign flush = br_taken_EX || ex_q.jal || ex_q.jalr;

    always_comb begin
        load_use  = 1'b0;
        raw_stall = 1'b0;
        if (FWD_EN != 0) begin
            load_use = ex_q.mem_read && src_hit(id_c, ex_q.rd_wen, ex_q.rd);
        end else begin
            raw_stall = src_hit(id_c, ex_q.rd_wen, ex_q.rd)
                     || src_hit(id_c, mem_q.rd_wen, mem_q.rd)
                     || src_hit(id_c, wb_q.rd_wen, wb_q.rd);
        end
        // A redirect discards the ID instruction anyway, so it overrides any stall.
        stall = !flush && (load_use || raw_stall || (stall_cnt != 2'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= 2'd0;
        end else begin
            ex_q  <= (flush || stall) ? '0 : id_c;
            mem_q <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                       wb_sel: ex_q.wb_sel, rd_wen: ex_q.rd_wen, rd: ex_q.rd};
            wb_q  <= '{wb_sel: mem_q.wb_sel, rd_wen: mem_q.rd_wen, rd: mem_q.rd};
            // First load-use bubble comes from the hazard itself; the counter
            // supplies the remaining MEM_LAT-1 while the load moves into MEM.
            if (flush) begin
                stall_cnt <= 2'd0;
            end else if (stall_cnt != 2'd0) begin
                stall_cnt <= stall_cnt - 2'd1;
            end else if (load_use) begin
                stall_cnt <= 2'(MEM_LAT - 1);
            end
        end
    end

    // MEM beats WB (younger result); a load in MEM has no data yet to forward.
    always_comb begin
        fwd_a_EX = FWD_RF;
        fwd_b_EX = FWD_RF;
        if (FWD_EN != 0) begin
            if (ex_q.use_rs1) begin
                if (mem_q.rd_wen && !mem_q.mem_read && (mem_q.rd == ex_q.rs1)) begin
                    fwd_a_EX = FWD_MEM;
                end else if (wb_q.rd_wen && (wb_q.rd == ex_q.rs1)) begin
                    fwd_a_EX = FWD_WB;
                end
            end
            if (ex_q.use_rs2) begin
                if (mem_q.rd_wen && !mem_q.mem_read && (mem_q.rd == ex_q.rs2)) begin
                    fwd_b_EX = FWD_MEM;
                end else if (wb_q.rd_wen && (wb_q.rd == ex_q.rs2)) begin
                    fwd_b_EX = FWD_WB;
                end
            end
        end
    end

    assign stall_IF      = stall;
    assign flush_IF      = flush;
    assign alu_src_b_EX  = ex_q.alu_src_b;
    assign alu_a_pc_EX   = ex_q.alu_a_pc;
    assign alu_ctrl_EX   = ex_q.alu_ctrl;
    assign branch_EX     = ex_q.branch;
    assign jal_EX        = ex_q.jal;
    assign jalr_EX       = ex_q.jalr;
    assign mem_read_MEM  = mem_q.mem_read;
    assign mem_write_MEM = mem_q.mem_write;
    assign wb_sel_WB     = wb_q.wb_sel;
    assign rd_wen_WB     = wb_q.rd_wen;
    assign rd_WB         = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit. Three instances (MEM_LAT=1, MEM_LAT=2, FWD_EN=0)
// share the stimulus; only the selected one sees valid instructions.
// Writebacks are checked by a scoreboard monitor, hazard outputs inline.
module tb_pipe_ctrl_unit;
    import riscv_ctrl_pkg::*;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ADD_X3    = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] SUB_X4    = 32'h40518233; // sub  x4,x3,x5
    localparam logic [31:0] ADD_X0    = 32'h00208033; // add  x0,x1,x2
    localparam logic [31:0] SUB_X4_X0 = 32'h40500233; // sub  x4,x0,x5
    localparam logic [31:0] LW_X5     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_X6    = 32'h00128333; // add  x6,x5,x1
    localparam logic [31:0] BEQ_X1_X2 = 32'h00208463; // beq  x1,x2,+8
    localparam logic [31:0] JAL_X1    = 32'h008000EF; // jal  x1,+8
    localparam logic [31:0] ADDI_X7   = 32'h00100393; // addi x7,x0,1
    localparam logic [31:0] ILLEGAL   = 32'h0000007F;
    localparam logic [31:0] ADD_X4_33 = 32'h00318233; // add  x4,x3,x3

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = NOP;
    logic        valid = 1'b0;
    logic        br = 1'b0;
    logic [1:0]  sel = 2'd0;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] exp_q[$]; // {rd, wb_sel}

    logic       stall_v[3], flush_v[3], illegal_v[3], src_b_v[3], a_pc_v[3];
    logic [3:0] alu_v[3];
    logic       branch_v[3], jal_v[3], jalr_v[3], mr_v[3], mw_v[3], wen_v[3];
    logic [1:0] fa_v[3], fb_v[3], wbs_v[3];
    logic [4:0] rd_v[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_ctrl_unit #(
            .MEM_LAT((g == 1) ? 2 : 1),
            .FWD_EN ((g == 2) ? 0 : 1)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .instr_ID       (instr),
            .instr_valid_ID (valid && (sel == 2'(g))),
            .br_taken_EX    (br && (sel == 2'(g))),
            .stall_IF       (stall_v[g]),
            .flush_IF       (flush_v[g]),
            .illegal_ID     (illegal_v[g]),
            .alu_src_b_EX   (src_b_v[g]),
            .alu_a_pc_EX    (a_pc_v[g]),
            .alu_ctrl_EX    (alu_v[g]),
            .branch_EX      (branch_v[g]),
            .jal_EX         (jal_v[g]),
            .jalr_EX        (jalr_v[g]),
            .fwd_a_EX       (fa_v[g]),
            .fwd_b_EX       (fb_v[g]),
            .mem_read_MEM   (mr_v[g]),
            .mem_write_MEM  (mw_v[g]),
            .wb_sel_WB      (wbs_v[g]),
            .rd_wen_WB      (wen_v[g]),
            .rd_WB          (rd_v[g])
        );
    end

    logic       stall_s, flush_s, illegal_s, a_pc_s, branch_s, jal_s, mr_s, wen_s;
    logic [3:0] alu_s;
    logic [1:0] fa_s, fb_s, wbs_s;
    logic [4:0] rd_s;
    assign stall_s   = stall_v[sel];
    assign flush_s   = flush_v[sel];
    assign illegal_s = illegal_v[sel];
    assign a_pc_s    = a_pc_v[sel];
    assign branch_s  = branch_v[sel];
    assign jal_s     = jal_v[sel];
    assign mr_s      = mr_v[sel];
    assign wen_s     = wen_v[sel];
    assign alu_s     = alu_v[sel];
    assign fa_s      = fa_v[sel];
    assign fb_s      = fb_v[sel];
    assign wbs_s     = wbs_v[sel];
    assign rd_s      = rd_v[sel];

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one ID slot after a rising edge, return at the following negedge.
    task automatic drive(input logic [31:0] i, input logic v = 1'b1,
                         input logic b = 1'b0, input logic r = 1'b0);
        @(posedge clk);
        #1;
        rst   = r;
        instr = i;
        valid = v;
        br    = b;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) drive(NOP);
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [1:0] ws);
        exp_q.push_back({rd, ws});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (wen_s === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: got write rd=%0d wb_sel=%0d, expected no write", rd_s, wbs_s);
            end else begin
                check("wb_rd_sel", {25'd0, rd_s, wbs_s}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with instructions streaming.
        sel = 2'd0;
        drive(ADD_X3, 1'b1, 1'b0, 1'b1);
        drive(ADD_X3, 1'b1, 1'b0, 1'b1);
        check("rst_wen", {31'd0, wen_s}, 32'd0);
        check("rst_rd", {27'd0, rd_s}, 32'd0);
        check("rst_alu", {28'd0, alu_s}, 32'd0);
        check("rst_memrd", {31'd0, mr_s}, 32'd0);
        check("rst_stall_flush", {30'd0, stall_s, flush_s}, 32'd0);

        // First ADD x3: write-back exactly 3 cycles after ID.
        drive(ADD_X3);
        expect_wb(5'd3, WB_ALU);
        drive(NOP);
        drive(NOP);
        check("lat_not_early", {31'd0, wen_s}, 32'd0);
        drive(NOP);
        check("lat_wen", {31'd0, wen_s}, 32'd1);
        check("lat_rd", {27'd0, rd_s}, 32'd3);
        drain(2);

        // Back-to-back RAW -> forward from MEM.
        drive(ADD_X3);    expect_wb(5'd3, WB_ALU);
        drive(SUB_X4);    expect_wb(5'd4, WB_ALU);
        drive(NOP);
        check("fwd_mem_a", {30'd0, fa_s}, 32'd2);
        check("fwd_mem_b", {30'd0, fb_s}, 32'd0);
        check("sub_alu", {28'd0, alu_s}, 32'h8);
        drain(3);

        // One instruction gap -> forward from WB.
        drive(ADD_X3);    expect_wb(5'd3, WB_ALU);
        drive(NOP);
        drive(SUB_X4);    expect_wb(5'd4, WB_ALU);
        drive(NOP);
        check("fwd_wb_a", {30'd0, fa_s}, 32'd1);
        drain(3);

        // Producer writes x0 -> no forwarding.
        drive(ADD_X0);
        drive(SUB_X4_X0); expect_wb(5'd4, WB_ALU);
        drive(NOP);
        check("fwd_x0_a", {30'd0, fa_s}, 32'd0);
        drain(3);

        // Load-use, MEM_LAT=1: one stall, one bubble, then WB forward.
        drive(LW_X5);     expect_wb(5'd5, WB_MEM);
        drive(ADD_X6);    expect_wb(5'd6, WB_ALU);
        check("lu1_stall", {31'd0, stall_s}, 32'd1);
        drive(ADD_X6);
        check("lu1_release", {31'd0, stall_s}, 32'd0);
        check("lu1_memrd", {31'd0, mr_s}, 32'd1);
        drive(NOP);
        check("lu1_fwd_a", {30'd0, fa_s}, 32'd1);
        check("lu1_fwd_b", {30'd0, fb_s}, 32'd0);
        drain(3);

        // Taken branch flushes the fall-through instruction.
        drive(BEQ_X1_X2);
        drive(ADDI_X7, 1'b1, 1'b1);
        check("br_flush", {31'd0, flush_s}, 32'd1);
        check("br_no_stall", {31'd0, stall_s}, 32'd0);
        check("br_branch_ex", {31'd0, branch_s}, 32'd1);
        check("br_alu_sub", {28'd0, alu_s}, 32'h8);
        drive(ADDI_X7, 1'b0);
        check("br_flush_1cyc", {31'd0, flush_s}, 32'd0);
        drain(3);

        // JAL x1: flush, operand A = PC, write-back of PC+4.
        drive(JAL_X1);    expect_wb(5'd1, WB_PC4);
        drive(NOP);
        check("jal_ex", {31'd0, jal_s}, 32'd1);
        check("jal_a_pc", {31'd0, a_pc_s}, 32'd1);
        check("jal_flush", {31'd0, flush_s}, 32'd1);
        drive(NOP, 1'b0);
        check("jal_flush_1cyc", {31'd0, flush_s}, 32'd0);
        drive(NOP);
        check("jal_wb_sel", {30'd0, wbs_s}, 32'd3);
        drain(2);

        // Load-use coinciding with a taken branch: flush wins.
        drive(LW_X5);     expect_wb(5'd5, WB_MEM);
        drive(ADD_X6, 1'b1, 1'b1);
        check("sim_stall", {31'd0, stall_s}, 32'd0);
        check("sim_flush", {31'd0, flush_s}, 32'd1);
        drive(NOP, 1'b0);
        check("sim_after", {31'd0, stall_s}, 32'd0);
        drain(3);

        // Illegal opcode: flagged, never written back.
        drive(ILLEGAL);
        check("illegal_flag", {31'd0, illegal_s}, 32'd1);
        drive(NOP);
        check("illegal_clear", {31'd0, illegal_s}, 32'd0);
        drain(4);

        // MEM_LAT=2 instance.
        sel = 2'd1;
        drive(NOP, 1'b1, 1'b0, 1'b1);
        drive(LW_X5);     expect_wb(5'd5, WB_MEM);
        drive(ADD_X6);    expect_wb(5'd6, WB_ALU);
        check("lu2_stall1", {31'd0, stall_s}, 32'd1);
        drive(ADD_X6);
        check("lu2_stall2", {31'd0, stall_s}, 32'd1);
        drive(ADD_X6);
        check("lu2_release", {31'd0, stall_s}, 32'd0);
        drain(4);

        // Flush during the first load-use cycle must not leave the counter running.
        drive(LW_X5);     expect_wb(5'd5, WB_MEM);
        drive(ADD_X6, 1'b1, 1'b1);
        check("lu2_flush_stall", {31'd0, stall_s}, 32'd0);
        check("lu2_flush", {31'd0, flush_s}, 32'd1);
        drive(NOP);
        check("lu2_cnt_cleared", {31'd0, stall_s}, 32'd0);
        drain(3);

        // Reset in the first load-use cycle: no residual bubbles, load is wiped.
        drive(LW_X5);
        drive(ADD_X6, 1'b1, 1'b0, 1'b1);
        check("rst_lu_stall", {31'd0, stall_s}, 32'd1);
        drive(ADD_X6);    expect_wb(5'd6, WB_ALU);
        check("rst_cnt_cleared", {31'd0, stall_s}, 32'd0);
        drain(4);

        // FWD_EN=0 instance: RAW stalls until the producer leaves WB.
        sel = 2'd2;
        drive(NOP, 1'b1, 1'b0, 1'b1);
        drive(ADD_X3);    expect_wb(5'd3, WB_ALU);
        drive(ADD_X4_33); expect_wb(5'd4, WB_ALU);
        check("nofwd_stall1", {31'd0, stall_s}, 32'd1);
        drive(ADD_X4_33);
        check("nofwd_stall2", {31'd0, stall_s}, 32'd1);
        check("nofwd_fwd_a_st", {30'd0, fa_s}, 32'd0);
        drive(ADD_X4_33);
        check("nofwd_stall3", {31'd0, stall_s}, 32'd1);
        drive(ADD_X4_33);
        check("nofwd_release", {31'd0, stall_s}, 32'd0);
        drive(NOP);
        check("nofwd_fwd_a", {30'd0, fa_s}, 32'd0);
        check("nofwd_fwd_b", {30'd0, fb_s}, 32'd0);
        drain(4);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation control unit for the 5-stage RV32I core.
- Decodes instr_ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB stage registers.
- Detects RAW hazards and generates forwarding selects, load-use stalls and branch/jump flushes.
- Load-use bubble length and the forwarding mode are parametrised. The previous decoder had no stage tracking, stall or flush.

Parameters:
- MEM_LAT, 1, data-memory read latency in cycles (1 or 2); sets the number of load-use bubbles.
- FWD_EN, 1, 1 = forwarding network active; 0 = stall on any RAW hazard against EX, MEM or WB.
- REG_AW, 5, register-address width.
- ALU_CW, 4, ALU control width ({funct7[5], funct3}).

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- instr_ID  in  32  instruction in ID
- instr_valid_ID  in  1  IF/ID register holds a real instruction
- br_taken_EX  in  1  branch resolved taken in EX (from comparator)
- stall_IF  out  1  hold PC and IF/ID
- flush_IF  out  1  invalidate IF/ID
- illegal_ID  out  1  unknown opcode in ID (combinational)
- alu_src_b_EX  out  1  1: rs2, 0: imm
- alu_a_pc_EX  out  1  ALU operand A = PC (auipc, jal)
- alu_ctrl_EX  out  ALU_CW  ALU operation
- branch_EX, jal_EX, jalr_EX  out  1 each  control-flow type in EX
- fwd_a_EX, fwd_b_EX  out  2 each  00 regfile, 01 WB, 10 MEM
- mem_read_MEM, mem_write_MEM  out  1 each  data-memory strobes
- wb_sel_WB  out  2  11 PC+4, 10 Mem, 01 ALU, 00 Imm
- rd_wen_WB  out  1  register-file write enable
- rd_WB  out  REG_AW  destination register

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high: when rst=1 at a posedge, every stage register loads a bubble (all fields 0) and the stall counter clears.
  - In that cycle all registered outputs become 0. stall_IF and flush_IF become 0 on the following cycle.
- Decode (ID, combinational):
  - R-type: src_b=rs2, ALU={f7[5],f3}, wb=01, wen=1.
  - OP-IMM: src_b=imm, ALU={f7[5] only for f3=101, else 0, f3}, wb=01, wen=1.
  - LOAD: imm, ADD, mem_read=1, wb=10, wen=1.
  - STORE: imm, ADD, mem_write=1, wen=0.
  - BRANCH: rs2, SUB, branch=1, wen=0.
  - JAL: jal=1, wb=11, wen=1.
  - JALR: jalr=1, src_b=imm, ADD, wb=11, wen=1.
  - LUI: wb=00, wen=1.
  - AUIPC: a_pc=1, imm, ADD, wb=01, wen=1.
  - Other opcodes: illegal_ID=1 and a bubble is issued.
  - Whenever rd=x0, wen is forced to 0.
- Register usage:
  - rs1 is used by R, OP-IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
  - Unused fields never raise a hazard.
- Advance: when not stalled, ID bundle -> EX -> MEM -> WB each cycle. Latency from ID to rd_wen_WB is 3 cycles.
- Forwarding (FWD_EN=1), per operand of the EX instruction:
  - 10 if MEM stage has wen, rd!=0, rd matches and is not a load.
  - Otherwise 01 if WB stage has wen and rd matches.
  - Otherwise 00. MEM has priority over WB.
- Load-use stall (FWD_EN=1):
  - Triggered when EX holds a load with rd matching a used ID source.
  - Behaviour: stall_IF=1 and a bubble enters EX, repeated for MEM_LAT cycles, counted by a down-counter.
  - With MEM_LAT=2, the second bubble also covers the case where the load sits in MEM.
  - After the bubbles, the dependent instruction proceeds with fwd=01.
- FWD_EN=0: stall_IF is asserted combinationally while any of EX, MEM or WB has wen and rd matching a used source. fwd_* are held at 00.
- Flush:
  - Triggered by br_taken_EX, or jal_EX or jalr_EX asserted.
  - Effect: flush_IF=1 and the ID/EX register loads a bubble on the next edge.
  - Flush beats stall: the stall counter clears and stall_IF is forced to 0.
- instr_valid_ID=0: the ID bundle is treated as a bubble and no hazard is raised.
- rst=1 during a stall or flush: reset wins. No residual bubble counting continues after reset.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - opcode and FUNCT3 constants (shared with Def.v)
  - wb_sel and fwd encodings
  - ctrl_t packed struct: alu_src_b, alu_a_pc, alu_ctrl, branch, jal, jalr, mem_read, mem_write, wb_sel, rd_wen, rd, rs1, rs2, use_rs1, use_rs2
- One combinational sub-module, ctrl_decode (instr -> ctrl_t, illegal). Stage registers, hazard logic and the counter stay in pipe_ctrl_unit.

Test Plan:
- Reset: rst=1 for 2 cycles with instructions streaming -> all outputs 0. First valid ADD (0x002081B3) gives rd_wen_WB=1, rd_WB=3 exactly 3 cycles after its ID cycle.
- Forwarding: ADD x3 then SUB x4,x3,x5 -> fwd_a_EX=10 on SUB in EX. With one NOP between them -> fwd_a_EX=01. With rd=x0 -> 00.
- Load-use, MEM_LAT=1: LW x5 then ADD x6,x5,x1 -> stall_IF=1 for exactly 1 cycle, one bubble, then ADD in EX with fwd_a=01. Repeat with MEM_LAT=2 -> 2 stall cycles.
- Branch flush: BEQ with br_taken_EX=1 -> flush_IF=1 for 1 cycle and the following instruction never writes back. Also JAL x1 -> wb_sel_WB=11.
- Simultaneous events: load-use stall coincides with br_taken_EX=1 -> stall_IF=0, flush_IF=1, counter cleared. rst mid-stall -> no stall afterwards.
- FWD_EN=0: ADD x3 then ADD x4,x3,x3 -> stall_IF high 3 cycles and fwd_* stay 00. Illegal opcode 0x0000007F -> illegal_ID=1 and no writes.
